// File: rtl/logic_gate.sv
// Registered two-input gate unit: seven bitwise Boolean functions of a and b,
// presented one clock after an enabled capture, with a matching valid strobe.
module logic_gate #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             valid,
   output logic [WIDTH-1:0] y0,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [WIDTH-1:0] y4,
   output logic [WIDTH-1:0] y5,
   output logic [WIDTH-1:0] y6
);

   typedef struct packed {
      logic [WIDTH-1:0] f_and;
      logic [WIDTH-1:0] f_or;
      logic [WIDTH-1:0] f_nand;
      logic [WIDTH-1:0] f_nor;
      logic [WIDTH-1:0] f_xor;
      logic [WIDTH-1:0] f_xnor;
      logic [WIDTH-1:0] f_not_a;
   } gate_res_t;

   gate_res_t res_c;
   gate_res_t res_q;

   // Pure per-bit functions; only consumed when en is high, so X on idle operands stays out.
   always_comb begin
      res_c         = '0;
      res_c.f_and   = a & b;
      res_c.f_or    = a | b;
      res_c.f_nand  = ~(a & b);
      res_c.f_nor   = ~(a | b);
      res_c.f_xor   = a ^ b;
      res_c.f_xnor  = ~(a ^ b);
      res_c.f_not_a = ~a;
   end

   // Result bank holds across idle cycles; reset value is all zeros, not the gate of zero operands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
         valid <= 1'b0;
      end else begin
         valid <= en;
         if (en) begin
            res_q <= res_c;
         end
      end
   end

   assign y0 = res_q.f_and;
   assign y1 = res_q.f_or;
   assign y2 = res_q.f_nand;
   assign y3 = res_q.f_nor;
   assign y4 = res_q.f_xor;
   assign y5 = res_q.f_xnor;
   assign y6 = res_q.f_not_a;

endmodule

// File: tb/tb_logic_gate.sv
// Directed bench for logic_gate: 8-bit and 1-bit instances share stimulus,
// expected results flow through a one-deep-latency scoreboard queue.
module tb_logic_gate;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [7:0] a;
   logic [7:0] b;

   logic       valid8;
   logic [7:0] y0_8, y1_8, y2_8, y3_8, y4_8, y5_8, y6_8;
   logic       valid1;
   logic [0:0] y0_1, y1_1, y2_1, y3_1, y4_1, y5_1, y6_1;

   logic_gate #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .valid(valid8),
      .y0(y0_8), .y1(y1_8), .y2(y2_8), .y3(y3_8), .y4(y4_8), .y5(y5_8), .y6(y6_8)
   );

   logic_gate #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .en(en), .a(a[0:0]), .b(b[0:0]), .valid(valid1),
      .y0(y0_1), .y1(y1_1), .y2(y2_1), .y3(y3_1), .y4(y4_1), .y5(y5_1), .y6(y6_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [55:0] sb [$];
   logic [55:0] held;
   logic        exp_valid;

   // Reference model written straight from the truth table, y0 in the top byte.
   function automatic logic [55:0] ref_fn(input logic [7:0] ai, input logic [7:0] bi);
      logic [7:0] r [7];
      for (int i = 0; i < 8; i++) begin
         case ({ai[i], bi[i]})
            2'b00:   {r[0][i], r[1][i], r[2][i], r[3][i], r[4][i], r[5][i], r[6][i]} = 7'b0011011;
            2'b01:   {r[0][i], r[1][i], r[2][i], r[3][i], r[4][i], r[5][i], r[6][i]} = 7'b0110101;
            2'b10:   {r[0][i], r[1][i], r[2][i], r[3][i], r[4][i], r[5][i], r[6][i]} = 7'b0110100;
            default: {r[0][i], r[1][i], r[2][i], r[3][i], r[4][i], r[5][i], r[6][i]} = 7'b1100010;
         endcase
      end
      return {r[0], r[1], r[2], r[3], r[4], r[5], r[6]};
   endfunction

   function automatic logic [6:0] bit0_of(input logic [55:0] v);
      return {v[48], v[40], v[32], v[24], v[16], v[8], v[0]};
   endfunction

   task automatic check_all(input string tag);
      logic [55:0] obs8;
      logic [6:0]  obs1;
      logic [6:0]  exp1;
      obs8 = {y0_8, y1_8, y2_8, y3_8, y4_8, y5_8, y6_8};
      obs1 = {y0_1, y1_1, y2_1, y3_1, y4_1, y5_1, y6_1};
      exp1 = bit0_of(held);
      checks++;
      assert (obs8 === held) else begin
         errors++;
         $error("FAIL %s y8 observed=%h expected=%h", tag, obs8, held);
      end
      checks++;
      assert (valid8 === exp_valid) else begin
         errors++;
         $error("FAIL %s valid8 observed=%b expected=%b", tag, valid8, exp_valid);
      end
      checks++;
      assert (obs1 === exp1) else begin
         errors++;
         $error("FAIL %s y1bit observed=%b expected=%b", tag, obs1, exp1);
      end
      checks++;
      assert (valid1 === exp_valid) else begin
         errors++;
         $error("FAIL %s valid1 observed=%b expected=%b", tag, valid1, exp_valid);
      end
   endtask

   // One clock: drive at negedge, optional sub-cycle reset pulse, check #1 after posedge.
   task automatic cycle(input logic e, input logic [7:0] ai, input logic [7:0] bi,
                        input bit rst_pulse, input string tag);
      @(negedge clk);
      en = e;
      a  = ai;
      b  = bi;
      if (rst_pulse) begin
         #2 rst_n = 1'b0;
         #1;
         sb.delete();
         held      = '0;
         exp_valid = 1'b0;
         check_all({tag, "_async"});
         #1 rst_n = 1'b1;
      end
      if (e) sb.push_back(ref_fn(ai, bi));
      @(posedge clk);
      #1;
      if (e) begin
         checks++;
         assert (sb.size() == 1) else begin
            errors++;
            $error("FAIL %s sb_depth observed=%0d expected=1", tag, sb.size());
         end
         if (sb.size() != 0) held = sb.pop_front();
         exp_valid = 1'b1;
      end else begin
         exp_valid = 1'b0;
      end
      check_all(tag);
   endtask

   initial begin
      logic [7:0] ra, rb;
      rst_n     = 1'b0;
      en        = 1'b1;
      a         = 8'hFF;
      b         = 8'hFF;
      held      = '0;
      exp_valid = 1'b0;

      // Reset held for 3 edges with active-looking inputs
      #1 check_all("reset_t0");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check_all("reset_hold");
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Exhaustive 2-bit operand sweep (bit 0 drives the WIDTH=1 instance)
      cycle(1'b1, 8'h00, 8'h00, 1'b0, "sweep00");
      cycle(1'b1, 8'h00, 8'hFF, 1'b0, "sweep01");
      cycle(1'b1, 8'hFF, 8'h00, 1'b0, "sweep10");
      cycle(1'b1, 8'hFF, 8'hFF, 1'b0, "sweep11");

      // Hold: capture 10, then idle with toggling and undefined operands
      cycle(1'b1, 8'hFF, 8'h00, 1'b0, "hold_cap");
      cycle(1'b0, 8'h00, 8'hFF, 1'b0, "hold1");
      cycle(1'b0, 8'hA5, 8'h5A, 1'b0, "hold2");
      cycle(1'b0, 8'bx,  8'bx,  1'b0, "hold_x");
      cycle(1'b0, 8'h3C, 8'hC3, 1'b0, "hold4");
      cycle(1'b0, 8'hFF, 8'hFF, 1'b0, "hold5");

      // Mixed-bit pattern
      cycle(1'b1, 8'hF0, 8'hCC, 1'b0, "f0_cc");
      checks++;
      assert ({y0_8, y1_8, y2_8, y3_8, y4_8, y5_8, y6_8} === 56'hC0_FC_3F_03_3C_C3_0F) else begin
         errors++;
         $error("FAIL f0_cc_const observed=%h expected=C0FC3F033CC30F",
                {y0_8, y1_8, y2_8, y3_8, y4_8, y5_8, y6_8});
      end

      // Mid-stream reset pulse shorter than a cycle
      for (int i = 0; i < 6; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         cycle(1'b1, ra, rb, (i == 3), "midrst");
      end
      cycle(1'b0, 8'h12, 8'h34, 1'b0, "post_rst_idle");
      cycle(1'b1, 8'h96, 8'h0F, 1'b0, "post_rst_cap");

      // Back-to-back throughput
      for (int i = 0; i < 100; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         cycle(1'b1, ra, rb, 1'b0, "stream");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_gate.md
Name: logic_gate

Overview:
- Registered two-input logic-gate unit: computes seven bitwise Boolean functions of operands a and b and presents them on y0..y6 one clock after capture.
- Used as a basic gate primitive and as a bring-up/teaching block in the gate library.
- Operands are WIDTH-bit vectors; each output bit depends only on the same-index bits of a and b.

Parameters:
- WIDTH, 1, bit width of operands a, b and every output y0..y6 (legal range 1..64).

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all registers immediately, deassertion is synchronised externally.
- en  input  1  capture enable; when 1, a/b are sampled on the rising clk edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- valid  output  1  high for exactly the cycle(s) in which y0..y6 hold results of a capture made on the previous edge.
- y0  output  WIDTH  a AND b.
- y1  output  WIDTH  a OR b.
- y2  output  WIDTH  a NAND b.
- y3  output  WIDTH  a NOR b.
- y4  output  WIDTH  a XOR b.
- y5  output  WIDTH  a XNOR b.
- y6  output  WIDTH  NOT a (b ignored).

Behaviour:
- Reset (rst_n=0, asynchronous): y0..y6 = all zeros, valid = 0, held for as long as rst_n is low regardless of clk, en, a, b.
- Reset clears outputs to zero even though NAND/NOR/XNOR/NOT of zero operands would be ones; zero is the defined reset value.
- Rising clk edge with rst_n=1 and en=1: all seven results are computed from the a/b values present at that edge and registered; valid <= 1.
- Rising clk edge with rst_n=1 and en=0: y0..y6 hold their previous values; valid <= 0.
- Latency: exactly one clock from the capturing edge to the result on the outputs. Throughput: one result per cycle with en held high.
- The outputs are purely registered, with no combinational path from a/b/en to any output.
- Bitwise: for every bit i, yk[i] is a function only of a[i] and b[i]. No carries and no cross-bit interaction.
- Truth table per bit (a,b -> y0..y6):
  - 00 -> 0,0,1,1,0,1,1
  - 01 -> 0,1,1,0,1,0,1
  - 10 -> 0,1,1,0,1,0,0
  - 11 -> 1,1,0,0,0,1,0
- Reset asserted mid-stream: outputs clear immediately. The first valid result after release comes one edge after the first en=1 edge.
- X on a/b with en=0 must not propagate to the outputs.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a=1,b=1,en=1 -> y0..y6=0 and valid=0 throughout. Drop rst_n asynchronously between edges while outputs are nonzero -> outputs clear without waiting for a clock edge.
- Exhaustive WIDTH=1 sweep with en=1, applying a,b = 00,01,10,11 on consecutive cycles -> one cycle later each step matches the truth table: 00->0011011, 01->0110101, 10->0110100, 11->1100010; valid=1 on each.
- Hold: capture a=1,b=0, then en=0 for 5 cycles while toggling a/b -> y0..y6 stay 0110100 and valid=0 after the first hold edge.
- WIDTH=8 with a=8'hF0, b=8'hCC -> y0=C0, y1=FC, y2=3F, y3=03, y4=3C, y5=C3, y6=0F.
- Reset mid-stream: stream random a/b with en=1, pulse rst_n low for less than one cycle -> outputs go to 0 immediately; normal results resume one edge after the first en=1 edge following release.
- Back-to-back throughput: 100 random a/b pairs with en=1 continuously -> each output equals the reference function of the previous cycle's inputs, with no bubbles.
